serial_alu_ctrl: RTL

Bit-serial sequencer that drives one externally instantiated 1-bit ALU slice (AND/OR/ADD/SUB/SLT, 3-bit op code) over WIDTH cycles to produce a full-width result. It serves the low-area multi-cycle execute path: the pipeline issues one operation, stalls on `ready`, and consumes `result` when `done` pulses. The controller owns the carry chain, the operand shifting, and the SLT fix-up that moves the MSB sign into bit 0.

---
 rtl/serial_alu_ctrl_pkg.sv | 27 ++
 rtl/serial_alu_ctrl.sv | 120 ++++++++++++
 2 files changed

// File: rtl/serial_alu_ctrl_pkg.sv
// Shared op-code constants, FSM state encoding and op-class helpers for the
// bit-serial ALU sequencer.
package serial_alu_ctrl_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
               (op == OP_SUB) || (op == OP_SLT);
    endfunction

    // Ops that use the carry chain and therefore report a carry out.
    function automatic logic op_is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/serial_alu_ctrl.sv
// Bit-serial sequencer: walks an external 1-bit ALU slice over WIDTH cycles,
// LSB first, owning the carry chain, operand shifting and the SLT fix-up.
module serial_alu_ctrl
    import serial_alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry_out,
    output logic             illegal,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic             slice_less,
    output logic [2:0]       slice_signal,
    input  logic             slice_out,
    input  logic             slice_set,
    input  logic             slice_cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sh, b_sh, r_sh;
    logic [CNT_W-1:0] cnt;
    logic             cq;
    logic [2:0]       op_q;
    logic             last_bit;
    logic [WIDTH-1:0] final_value;

    assign last_bit    = (state == ST_RUN) && (cnt == CNT_LAST);
    assign final_value = (op_q == OP_SLT) ? {{(WIDTH-1){1'b0}}, slice_set}
                                          : {slice_out, r_sh[WIDTH-1:1]};

    assign ready        = (state == ST_IDLE);
    assign done         = (state == ST_DONE);
    assign slice_a      = a_sh[0];
    assign slice_b      = b_sh[0];
    assign slice_cin    = cq;
    assign slice_less   = 1'b0;
    assign slice_signal = op_q;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // NOTE: next_state is defaulted before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = op_is_legal(op) ? ST_RUN : ST_DONE;
            ST_RUN:  if (cnt == CNT_LAST) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: state is written with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh      <= '0;
            b_sh      <= '0;
            cnt       <= '0;
            cq        <= 1'b0;
            op_q      <= OP_AND;
            result    <= '0;
            zero      <= 1'b1;
            carry_out <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && op_is_legal(op)) begin
                        a_sh <= a;
                        b_sh <= b;
                        op_q <= op;
                        cnt  <= '0;
                        cq   <= op[2];  // +1 of two's complement for SUB/SLT
                    end else if (start) begin
                        result    <= '0;
                        zero      <= 1'b1;
                        carry_out <= 1'b0;
                        illegal   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    cq   <= slice_cout;
                    cnt  <= last_bit ? '0 : cnt + 1'b1;
                    if (last_bit) begin
                        result    <= final_value;
                        zero      <= (final_value == '0);
                        carry_out <= op_is_arith(op_q) & slice_cout;
                        illegal   <= 1'b0;
                    end
                end
                ST_DONE: illegal <= 1'b0;
                default: illegal <= 1'b0;
            endcase
        end
    end

    // NOTE: r_sh has no reset; every bit is rewritten before it is ever read.
    always_ff @(posedge clk) begin
        if (state == ST_RUN) r_sh <= {slice_out, r_sh[WIDTH-1:1]};
    end

endmodule
